// File: rtl/emmu_loader.sv
// EMMU translation-table loader: on a start pulse, walks a range of table entries and
// issues one low-word and one high-word emesh register write per entry.
module emmu_loader #(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] MMU_BASE = '0,
  localparam int           PW       = 2*AW+40
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          start,
  input  logic [11:0]   entry_first,
  input  logic [12:0]   entry_count,
  input  logic [43:0]   trans_base,
  input  logic [43:0]   trans_stride,
  input  logic          reg_wait_in,
  output logic          reg_access_out,
  output logic [PW-1:0] reg_packet_out,
  output logic          busy,
  output logic          done
);

  // The state names the word the output register will take on its next load,
  // so every output is a flop and the packet stream has no bubbles.
  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [11:0]   idx;
  logic [12:0]   remaining;
  logic [43:0]   value;
  logic [43:0]   stride;

  logic          advance;
  logic          launch;

  logic          access_nxt;
  logic [PW-1:0] packet_nxt;
  logic          busy_nxt;
  logic          done_nxt;

  logic [AW-1:0] lo_addr;
  logic [AW-1:0] hi_addr;

  function automatic logic [PW-1:0] make_packet(input logic [AW-1:0] addr,
                                                 input logic [AW-1:0] data);
    logic [PW-1:0] p;
    p           = '0;
    p[0]        = 1'b1;
    p[2:1]      = 2'b10;
    p[8 +: AW]  = addr;
    p[AW+8 +: AW] = data;
    return p;
  endfunction

  // The output register may take a new word unless it is holding a stalled packet.
  assign advance = !(reg_access_out && reg_wait_in);
  // A start while busy (including the done cycle) is dropped, not queued.
  assign launch  = (state == IDLE) && start && !busy;

  assign lo_addr = MMU_BASE | AW'({idx, 3'b000});
  assign hi_addr = MMU_BASE | AW'({idx, 3'b100});

  // NOTE: state and datapath flops use non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every combinational output gets a default before the case so no latch
  // is inferred on paths that do not assign it.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (launch) begin
          state_nxt = (entry_count == 13'd0) ? DONE : LO;
        end
      end
      LO: begin
        if (advance) begin
          state_nxt = HI;
        end
      end
      HI: begin
        if (advance) begin
          state_nxt = (remaining == 13'd1) ? DONE : LO;
        end
      end
      DONE: begin
        if (advance) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    access_nxt = 1'b0;
    packet_nxt = '0;
    busy_nxt   = (state != IDLE);
    done_nxt   = (state == DONE);
    unique case (state)
      LO: begin
        access_nxt = 1'b1;
        packet_nxt = make_packet(lo_addr, AW'(value[31:0]));
      end
      HI: begin
        access_nxt = 1'b1;
        packet_nxt = make_packet(hi_addr, AW'(value[43:32]));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      reg_access_out <= 1'b0;
      reg_packet_out <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else if (advance) begin
      reg_access_out <= access_nxt;
      reg_packet_out <= packet_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
    end
  end

  // Entry walk: step to the next entry once its high word is handed to the output.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      idx       <= '0;
      remaining <= '0;
      value     <= '0;
      stride    <= '0;
    end else if (launch) begin
      idx       <= entry_first;
      remaining <= entry_count;
      value     <= trans_base;
      stride    <= trans_stride;
    end else if (state == HI && advance && remaining != 13'd1) begin
      idx       <= idx + 12'd1;
      remaining <= remaining - 13'd1;
      value     <= value + stride;
    end
  end

endmodule

// File: tb/tb_emmu_loader.sv
// Scoreboard bench for emmu_loader: tests queue expected packets, a monitor pops and
// compares each accepted packet and checks that stalled packets hold steady.
module tb_emmu_loader;

  localparam int AW = 32;
  localparam int PW = 2*AW+40;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          start = 1'b0;
  logic [11:0]   entry_first = '0;
  logic [12:0]   entry_count = '0;
  logic [43:0]   trans_base = '0;
  logic [43:0]   trans_stride = '0;
  logic          reg_wait_in = 1'b0;
  logic          reg_access_out;
  logic [PW-1:0] reg_packet_out;
  logic          busy;
  logic          done;

  int vectors = 0;
  int errors  = 0;
  int done_seen = 0;

  logic [PW-1:0] exp_q[$];

  always #5 clk = ~clk;

  emmu_loader #(.AW(AW), .MMU_BASE(32'h0)) dut (
    .clk            (clk),
    .nreset         (nreset),
    .start          (start),
    .entry_first    (entry_first),
    .entry_count    (entry_count),
    .trans_base     (trans_base),
    .trans_stride   (trans_stride),
    .reg_wait_in    (reg_wait_in),
    .reg_access_out (reg_access_out),
    .reg_packet_out (reg_packet_out),
    .busy           (busy),
    .done           (done)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pkt(input logic [31:0] addr, input logic [31:0] data);
    return {32'h0, data, addr, 5'b0, 2'b10, 1'b1};
  endfunction

  // Monitor: sampled on the falling edge, a packet with wait low transfers on the next rise.
  logic          prev_stall = 1'b0;
  logic [PW-1:0] prev_packet = '0;
  always @(negedge clk) begin
    if (!nreset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_access_held", {127'b0, reg_access_out}, 128'd1);
        check("stall_packet_held", 128'(reg_packet_out), 128'(prev_packet));
      end
      if (done) done_seen++;
      if (reg_access_out && !reg_wait_in) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_packet: got %0h expected none", reg_packet_out);
        end else begin
          check("packet", 128'(reg_packet_out), 128'(exp_q.pop_front()));
        end
      end
      prev_stall  = reg_access_out && reg_wait_in;
      prev_packet = reg_packet_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the edge that samples start.
  task automatic start_load(input logic [11:0] f, input logic [12:0] c,
                            input logic [43:0] b, input logic [43:0] s);
    tick();
    entry_first  = f;
    entry_count  = c;
    trans_base   = b;
    trans_stride = s;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_seen;
    int n  = 0;
    while (done_seen == d0 && n < budget) begin
      tick();
      n++;
    end
    check("done_within_budget", 128'(done_seen != d0), 128'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;

    // Reset state
    #12;
    check("reset_access", {127'b0, reg_access_out}, 128'd0);
    check("reset_packet", 128'(reg_packet_out), 128'd0);
    check("reset_busy",   {127'b0, busy}, 128'd0);
    check("reset_done",   {127'b0, done}, 128'd0);
    nreset = 1'b1;
    tick();

    // Single entry with cycle-exact timing
    exp_q.push_back(pkt(32'h28, 32'h456789AB));
    exp_q.push_back(pkt(32'h2C, 32'h00000123));
    start_load(12'd5, 13'd1, 44'h123_4567_89AB, 44'h0);
    check("single_access_at_start", {127'b0, reg_access_out}, 128'd0);
    check("single_busy_at_start",   {127'b0, busy}, 128'd0);
    tick();
    check("single_access_c1", {127'b0, reg_access_out}, 128'd1);
    check("single_busy_c1",   {127'b0, busy}, 128'd1);
    tick();
    check("single_packet_c2", 128'(reg_packet_out), 128'(pkt(32'h2C, 32'h123)));
    tick();
    check("single_done_c3",   {127'b0, done}, 128'd1);
    check("single_access_c3", {127'b0, reg_access_out}, 128'd0);
    check("single_busy_c3",   {127'b0, busy}, 128'd1);
    tick();
    check("single_busy_c4",   {127'b0, busy}, 128'd0);
    check("single_done_c4",   {127'b0, done}, 128'd0);
    check("single_queue_empty", 128'(exp_q.size()), 128'd0);

    // Stride with a three-cycle stall
    exp_q.push_back(pkt(32'h00, 32'h100000));
    exp_q.push_back(pkt(32'h04, 32'h0));
    exp_q.push_back(pkt(32'h08, 32'h200000));
    exp_q.push_back(pkt(32'h0C, 32'h0));
    exp_q.push_back(pkt(32'h10, 32'h300000));
    exp_q.push_back(pkt(32'h14, 32'h0));
    start_load(12'd0, 13'd3, 44'h100000, 44'h100000);
    tick();
    tick();
    reg_wait_in = 1'b1;
    repeat (3) tick();
    reg_wait_in = 1'b0;
    wait_done(40);
    check("stride_queue_empty", 128'(exp_q.size()), 128'd0);

    // Index wrap 4095 -> 0
    exp_q.push_back(pkt(32'h7FF8, 32'h1));
    exp_q.push_back(pkt(32'h7FFC, 32'h0));
    exp_q.push_back(pkt(32'h0000, 32'h2));
    exp_q.push_back(pkt(32'h0004, 32'h0));
    start_load(12'd4095, 13'd2, 44'h1, 44'h1);
    wait_done(20);
    check("wrap_queue_empty", 128'(exp_q.size()), 128'd0);

    // Value wrap modulo 2^44
    exp_q.push_back(pkt(32'h7FF8, 32'hFFFFFFFF));
    exp_q.push_back(pkt(32'h7FFC, 32'h00000FFF));
    exp_q.push_back(pkt(32'h0000, 32'h0));
    exp_q.push_back(pkt(32'h0004, 32'h0));
    start_load(12'd4095, 13'd2, 44'hFFF_FFFF_FFFF, 44'h1);
    wait_done(20);
    check("valwrap_queue_empty", 128'(exp_q.size()), 128'd0);
    repeat (2) tick();

    // Count zero; a start during the done cycle is dropped
    d0 = done_seen;
    start_load(12'd3, 13'd0, 44'h55, 44'h1);
    check("zero_done_at_start", {127'b0, done}, 128'd0);
    tick();
    check("zero_done_c1",   {127'b0, done}, 128'd1);
    check("zero_access_c1", {127'b0, reg_access_out}, 128'd0);
    entry_count = 13'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_done_c2", {127'b0, done}, 128'd0);
    check("zero_busy_c2", {127'b0, busy}, 128'd0);
    repeat (6) tick();
    check("zero_busy_later", {127'b0, busy}, 128'd0);
    check("zero_single_done", 128'(done_seen - d0), 128'd1);

    // Start while busy is ignored
    exp_q.push_back(pkt(32'h50, 32'h5));
    exp_q.push_back(pkt(32'h54, 32'h0));
    exp_q.push_back(pkt(32'h58, 32'h15));
    exp_q.push_back(pkt(32'h5C, 32'h0));
    start_load(12'd10, 13'd2, 44'h5, 44'h10);
    tick();
    entry_first = 12'd0;
    entry_count = 13'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(20);
    repeat (6) tick();
    check("busystart_queue_empty", 128'(exp_q.size()), 128'd0);
    check("busystart_idle", {127'b0, busy}, 128'd0);

    // Reset while the first HI word is presented
    exp_q.push_back(pkt(32'h00, 32'h0));
    start_load(12'd0, 13'd3, 44'h0, 44'h0);
    tick();
    tick();
    check("rst_hi_presented", 128'(reg_packet_out), 128'(pkt(32'h04, 32'h0)));
    nreset = 1'b0;
    #1;
    check("rst_access", {127'b0, reg_access_out}, 128'd0);
    check("rst_packet", 128'(reg_packet_out), 128'd0);
    check("rst_busy",   {127'b0, busy}, 128'd0);
    check("rst_done",   {127'b0, done}, 128'd0);
    check("rst_lo_consumed", 128'(exp_q.size()), 128'd0);
    tick();
    nreset = 1'b1;
    tick();
    exp_q.push_back(pkt(32'h38, 32'hABC));
    exp_q.push_back(pkt(32'h3C, 32'h0));
    start_load(12'd7, 13'd1, 44'hABC, 44'h0);
    wait_done(20);
    check("post_rst_queue_empty", 128'(exp_q.size()), 128'd0);

    // Full table with random pushback
    for (int i = 0; i < 4096; i++) begin
      exp_q.push_back(pkt(32'(i * 8), 32'(i)));
      exp_q.push_back(pkt(32'(i * 8 + 4), 32'h0));
    end
    d0 = done_seen;
    start_load(12'd0, 13'd4096, 44'h0, 44'h1);
    for (int n = 0; n < 40000 && done_seen == d0; n++) begin
      reg_wait_in = ($urandom_range(0, 3) == 0);
      tick();
    end
    reg_wait_in = 1'b0;
    repeat (6) tick();
    check("full_queue_empty", 128'(exp_q.size()), 128'd0);
    check("full_done_once", 128'(done_seen - d0), 128'd1);
    check("full_idle", {127'b0, busy}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/emmu_loader.md
Name: emmu_loader

Overview:
- Configuration initiator that programs the EMMU translation table over the register-write packet interface.
- On a start pulse it walks a range of table entries and emits two emesh write packets per entry (low word, then high word), with translation value = base + i*stride.
- Sits between the host/boot sequencer and the EMMU config write port (reg_access/reg_packet), removing per-entry software writes.

Parameters:
AW, 32, emesh address width; PW = 2*AW+40 (localparam)
MMU_BASE, 32'h0, register base address of the table; bits [14:0] must be zero

Ports:
clk  in  1  single clock
nreset  in  1  async active-low reset
start  in  1  one-cycle request to begin a load; ignored while busy=1
entry_first  in  12  first table index
entry_count  in  13  number of entries, 0..4096
trans_base  in  44  translation value for the first entry
trans_stride  in  44  increment added per entry
reg_wait_in  in  1  pushback from the EMMU config port
reg_access_out  out  1  valid write packet
reg_packet_out  out  PW  emesh write packet
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, nreset=0): state=IDLE; reg_access_out=0, reg_packet_out=0, busy=0, done=0. Reset mid-load aborts immediately, with no further packets. A partially written entry is left as-is.
- Registers: on start in IDLE, latch idx=entry_first, remaining=entry_count, value=trans_base, stride=trans_stride.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE + start + count!=0 -> LO.
  - IDLE + start + count==0 -> DONE; no packets are emitted.
  - LO, accepted -> HI.
  - HI, accepted and remaining==1 -> DONE.
  - HI, accepted and remaining>1 -> LO, with idx+1, value+stride, remaining-1.
  - DONE -> IDLE after 1 cycle, with done=1 during that cycle.
- Outputs and timing:
  - All outputs are registered.
  - start at edge N -> reg_access_out=1 and busy=1 after edge N+1.
  - busy=0 in IDLE; busy=1 in LO, HI and DONE.
- Handshake:
  - A packet transfers on a rising edge where reg_access_out=1 and reg_wait_in=0.
  - While reg_wait_in=1, reg_access_out and reg_packet_out hold stable.
  - After an accepted packet, the next packet is presented on the following cycle (no bubble) unless the load is complete.
  - After the final HI acceptance, reg_access_out=0.
- Packet format (AW=32):
  - [0] write=1
  - [2:1] datamode=2'b10
  - [7:3] ctrlmode=0
  - [39:8] dstaddr
  - [71:40] data
  - [103:72] srcaddr=0
- Addressing and data:
  - LO packet: dstaddr = MMU_BASE | {idx,3'b000}; data = value[31:0].
  - HI packet: dstaddr = MMU_BASE | {idx,3'b100}; data = {20'b0, value[43:32]}.
- Arithmetic:
  - idx increments modulo 4096 (4095 -> 0).
  - value accumulates modulo 2^44.
  - remaining is 13 bits, so count=4096 writes every entry exactly once.
- Simultaneous events: start arriving in the same cycle as done, or while busy, is dropped and not queued.

Test Plan:
- Single entry: first=5, count=1, base=44'h123_4567_89AB, stride=0, no wait -> packets at cycles 1 and 2.
  - Packet 1: dstaddr=0x28, data=0x456789AB.
  - Packet 2: dstaddr=0x2C, data=0x00000123.
  - done=1 at cycle 3; busy falls at cycle 4.
- Stride with stall: first=0, count=3, base=0x100000, stride=0x100000, reg_wait_in=1 for cycles 2-4.
  - Required: 6 packets with LO data 0x100000, 0x200000, 0x300000.
  - Packet held unchanged during the stall; no packet lost or duplicated.
- Wrap: first=4095, count=2, base=1, stride=1 -> dstaddr sequence 0x7FF8, 0x7FFC, 0x0, 0x4 with LO data 1, 2.
  - Repeat with base=44'hFFF_FFFF_FFFF, stride=1: second entry is LO=0, HI=0.
- Count zero: start with count=0 -> no reg_access_out; done pulses 1 cycle after start.
- Reset and busy-start: assert start while busy=1 -> ignored, and total packet count equals the original request.
  - Deassert nreset mid-HI -> all outputs 0 immediately.
  - After release, a new start operates normally.
- Full table: count=4096, stride=1, random wait -> 8192 accepted packets, every index 0..4095 hit once in order; done exactly once.
